// File: rtl/sparse_pkg.sv
// Shared types and default constants for the sparsification scan block.
// State encoding plus default threshold and rounding quantum.
package sparse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sparse_state_e;

    localparam int SPARSE_THRESHOLD = 20;
    localparam int SPARSE_QUANT     = 5;

endpackage

// File: rtl/sparse_xform.sv
// Combinational sparsifying transform of one counter value.
// Values at or below THRESHOLD become 0; others round down to a QUANT multiple.
module sparse_xform
    import sparse_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int THRESHOLD = SPARSE_THRESHOLD,
    parameter int QUANT     = SPARSE_QUANT
) (
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout
);

    localparam logic [DATA_W-1:0] TH = DATA_W'(THRESHOLD);
    localparam logic [DATA_W-1:0] QU = DATA_W'(QUANT);

    // Zero small counters, otherwise drop the remainder modulo QUANT.
    always_comb begin
        Dout = '0;
        if (Din > TH) begin
            Dout = Din - (Din % QU);
        end
    end

endmodule

// File: rtl/sparse_scan_ctrl.sv
// One-pass read/transform/write-back sequencer over a counter RAM.
// Define SPARSE_STATS_EN to build the Nonzero_Count / Max_Value statistics.
module sparse_scan_ctrl
    import sparse_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int THRESHOLD = SPARSE_THRESHOLD,
    parameter int QUANT     = SPARSE_QUANT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Rd_En,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [DATA_W-1:0] Wr_Data,
    output logic [ADDR_W:0]   Nonzero_Count,
    output logic [DATA_W-1:0] Max_Value
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    sparse_state_e     state_q, state_d;
    logic              pass_start;
    logic [ADDR_W-1:0] rd_idx_q;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] xf_data;

    sparse_xform #(
        .DATA_W    (DATA_W),
        .THRESHOLD (THRESHOLD),
        .QUANT     (QUANT)
    ) u_xform (
        .Din  (Rd_Data),
        .Dout (xf_data)
    );

    // Next-state and control outputs; RAM-facing signals idle at 0.
    always_comb begin
        state_d    = state_q;
        pass_start = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        Rd_En      = 1'b0;
        Rd_Addr    = '0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = SCAN;
                    pass_start = 1'b1;
                end
            end
            SCAN: begin
                Busy    = 1'b1;
                Rd_En   = 1'b1;
                Rd_Addr = rd_idx_q;
                if (rd_idx_q == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                Busy = 1'b1;
                // Last write is in flight with no read behind it.
                if (wr_en_q && !rd_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Read index walks 0..DEPTH-1 during SCAN.
    always_ff @(posedge Clk) begin
        if (Reset || pass_start) rd_idx_q <= '0;
        else if (Rd_En)          rd_idx_q <= rd_idx_q + 1'b1;
    end

    // Track which read returns data next cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld_q  <= Rd_En;
            rd_addr_q <= Rd_Addr;
        end
    end

    // Registered write-back of the transformed value, zero when idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= rd_vld_q;
            wr_addr_q <= rd_vld_q ? rd_addr_q : '0;
            wr_data_q <= rd_vld_q ? xf_data : '0;
        end
    end

    assign Wr_En   = wr_en_q;
    assign Wr_Addr = wr_addr_q;
    assign Wr_Data = wr_data_q;

`ifdef SPARSE_STATS_EN
    logic [ADDR_W:0]   nz_q;
    logic [DATA_W-1:0] max_q;

    // Per-pass statistics, cleared on launch and held after Done.
    always_ff @(posedge Clk) begin
        if (Reset || pass_start) begin
            nz_q  <= '0;
            max_q <= '0;
        end else if (rd_vld_q) begin
            nz_q <= nz_q + (ADDR_W+1)'(xf_data != '0);
            if (xf_data > max_q) max_q <= xf_data;
        end
    end

    assign Nonzero_Count = nz_q;
    assign Max_Value     = max_q;
`else
    assign Nonzero_Count = '0;
    assign Max_Value     = '0;
`endif

endmodule

// File: tb/tb_sparse_scan_ctrl.sv
// Randomized self-checking bench for sparse_scan_ctrl with a RAM model.
// Expected values come from a per-counter reference transform and cycle formulas.
module tb_sparse_scan_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Busy, Done, Rd_En, Wr_En;
    logic [AW-1:0] Rd_Addr, Wr_Addr;
    logic [DW-1:0] Rd_Data;
    logic [DW-1:0] Wr_Data, Max_Value;
    logic [AW:0]   Nonzero_Count;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] img [DEPTH];
    logic [DW-1:0] mdl [DEPTH];
    int            wr_hits [DEPTH];
    logic          load = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int last_nz = 0;
    logic [DW-1:0] last_mx = '0;

    sparse_scan_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Busy          (Busy),
        .Done          (Done),
        .Rd_En         (Rd_En),
        .Rd_Addr       (Rd_Addr),
        .Rd_Data       (Rd_Data),
        .Wr_En         (Wr_En),
        .Wr_Addr       (Wr_Addr),
        .Wr_Data       (Wr_Data),
        .Nonzero_Count (Nonzero_Count),
        .Max_Value     (Max_Value)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i]     <= img[i];
                wr_hits[i] <= 0;
            end
        end else if (Wr_En) begin
            ram[Wr_Addr]     <= Wr_Data;
            wr_hits[Wr_Addr] <= wr_hits[Wr_Addr] + 1;
        end
        Rd_Data <= Rd_En ? ram[Rd_Addr] : '0;
    end

    function automatic logic [DW-1:0] ref_xf(input logic [DW-1:0] v);
        if (v <= 32'd20) return '0;
        return v - (v % 32'd5);
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ctl"}, 64'({Busy, Done, Rd_En, Wr_En, Rd_Addr, Wr_Addr}), 64'd0);
        check({tag, " wdata"}, 64'(Wr_Data), 64'd0);
    endtask

    task automatic load_ram();
        @(negedge Clk);
        Start = 1'b0;
        load  = 1'b1;
        @(negedge Clk);
        load = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = img[i];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            Start = 1'b0;
        end
`ifdef SPARSE_STATS_EN
        check("hold nz", 64'(Nonzero_Count), 64'(last_nz));
        check("hold max", 64'(Max_Value), 64'(last_mx));
`else
        check("hold nz", 64'(Nonzero_Count), 64'd0);
        check("hold max", 64'(Max_Value), 64'd0);
`endif
    endtask

    // Start in cycle 0; optional stray Start in noise_c and in the Done cycle.
    task automatic run_pass(input int noise_c);
        logic [DW-1:0] exp_w [DEPTH];
        int            nz;
        logic [DW-1:0] mx;
        bit            b, d, r, w;
        nz = 0;
        mx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_w[i] = ref_xf(mdl[i]);
            if (exp_w[i] != 0) nz++;
            if (exp_w[i] > mx) mx = exp_w[i];
        end
        @(negedge Clk);
        Start = 1'b1;
        for (int c = 1; c <= DEPTH + 3; c++) begin
            @(negedge Clk);
            Start = (c == noise_c) || (noise_c > 0 && c == DEPTH + 3);
            b = (c <= DEPTH + 2);
            d = (c == DEPTH + 3);
            r = (c <= DEPTH);
            w = (c >= 3 && c <= DEPTH + 2);
            check($sformatf("ctl c%0d", c), 64'({Busy, Done, Rd_En, Wr_En}),
                  64'({b, d, r, w}));
            check($sformatf("raddr c%0d", c), 64'(Rd_Addr),
                  r ? 64'(c - 1) : 64'd0);
            check($sformatf("waddr c%0d", c), 64'(Wr_Addr),
                  w ? 64'(c - 3) : 64'd0);
            check($sformatf("wdata c%0d", c), 64'(Wr_Data),
                  w ? 64'(exp_w[c - 3]) : 64'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ram[%0d]", i), 64'(ram[i]), 64'(exp_w[i]));
            mdl[i] = exp_w[i];
        end
`ifdef SPARSE_STATS_EN
        check("nz", 64'(Nonzero_Count), 64'(nz));
        check("max", 64'(Max_Value), 64'(mx));
`else
        check("nz", 64'(Nonzero_Count), 64'd0);
        check("max", 64'(Max_Value), 64'd0);
`endif
        last_nz = nz;
        last_mx = mx;
    endtask

    task automatic reset_mid_pass();
        @(negedge Clk);
        Start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            check($sformatf("rst ctl c%0d", c), 64'({Busy, Rd_En}), 64'(2'b11));
        end
        Reset = 1'b1;
        @(negedge Clk);
        check_quiet("rst c6");
        check("rst nz", 64'({Nonzero_Count, Max_Value}), 64'd0);
        Reset = 1'b0;
        for (int c = 7; c <= DEPTH + 6; c++) begin
            @(negedge Clk);
            check_quiet($sformatf("post-rst c%0d", c));
            check($sformatf("post-rst done c%0d", c), 64'(Done), 64'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("rst ram[%0d]", i), 64'(ram[i]),
                  i < 3 ? 64'(ref_xf(img[i])) : 64'(img[i]));
            check($sformatf("rst hits[%0d]", i), 64'(wr_hits[i]),
                  i < 3 ? 64'd1 : 64'd0);
            mdl[i] = ram[i];
        end
        last_nz = 0;
        last_mx = '0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_quiet("reset");
        check("reset stats", 64'({Nonzero_Count, Max_Value}), 64'd0);
        Reset = 1'b0;

        img[0] = 32'd0;    img[1] = 32'd20;  img[2] = 32'd21;
        img[3] = 32'd24;   img[4] = 32'd25;  img[5] = 32'd99;
        img[6] = 32'd1000; img[7] = 32'hFFFF_FFFF;
        load_ram();
        run_pass(-1);
        idle(3);
        run_pass(4);
        run_pass(-1);
        idle(2);

        for (int i = 0; i < DEPTH; i++) img[i] = 32'd20;
        load_ram();
        run_pass(-1);
        idle(2);

        for (int i = 0; i < DEPTH; i++) img[i] = $urandom_range(0, 200);
        load_ram();
        reset_mid_pass();
        idle(1);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < DEPTH; i++)
                img[i] = ($urandom % 2 == 0) ? 32'($urandom_range(0, 60))
                                              : 32'($urandom);
            load_ram();
            run_pass(($urandom % 2 == 0) ? int'($urandom_range(1, DEPTH + 2)) : -1);
            if ($urandom % 2 == 0) run_pass(-1);
            idle(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
